// File: rtl/cgra_axi_pkg.sv
// Shared AXI read-side types and helpers for the CGRA memory interface blocks.
package cgra_axi_pkg;

    localparam int AXI_LEN_W  = 8;
    localparam int AXI_ADDR_W = 64;

    function automatic int col_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Address field is sized for the widest supported bus; narrower users truncate.
    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
    } ar_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer wins; the pointer
// moves past the winner only when the grant is actually taken.
module rr_arbiter
    import cgra_axi_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = col_idx_w(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grantIdx_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] candIdx;
    logic          found;
    int            cand;

    always_comb begin
        grant_o    = '0;
        grantIdx_o = '0;
        found      = 1'b0;
        cand       = 0;
        candIdx    = '0;
        for (int k = 0; k < N; k++) begin
            cand    = (int'(ptr_q) + k) % N;
            candIdx = IW'(cand);
            if (!found && req_i[candIdx]) begin
                found            = 1'b1;
                grant_o[candIdx] = 1'b1;
                grantIdx_o       = candIdx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = IW'((int'(grantIdx_o) + 1) % N);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hbm_rd_arbiter.sv
// Shares one AXI4 read port among NUM_COL columns: round-robin AR issue through a
// single-entry slot, R beats steered back in grant order via an in-order index FIFO.
module hbm_rd_arbiter
    import cgra_axi_pkg::*;
#(
    parameter int NUM_COL   = 4,
    parameter int ADDR_W    = 64,   // must not exceed AXI_ADDR_W
    parameter int DATA_W    = 512,
    parameter int MAX_OUTST = 8     // power of 2, at least 2
) (
    input  logic                         ap_clk,
    input  logic                         areset,
    input  logic [NUM_COL*ADDR_W-1:0]    col_araddr,
    input  logic [NUM_COL*AXI_LEN_W-1:0] col_arlen,
    input  logic [NUM_COL-1:0]           col_arvalid,
    output logic [NUM_COL-1:0]           col_arready,
    output logic [DATA_W-1:0]            col_rdata,
    output logic [NUM_COL-1:0]           col_rlast,
    output logic [NUM_COL-1:0]           col_rvalid,
    input  logic [NUM_COL-1:0]           col_rready,
    output logic [ADDR_W-1:0]            hbm_araddr,
    output logic [AXI_LEN_W-1:0]         hbm_arlen,
    output logic                         hbm_arvalid,
    input  logic                         hbm_arready,
    input  logic [DATA_W-1:0]            hbm_rdata,
    input  logic                         hbm_rlast,
    input  logic                         hbm_rvalid,
    output logic                         hbm_rready,
    output logic                         err_orphan
);

    localparam int IW = col_idx_w(NUM_COL);
    localparam int PW = col_idx_w(MAX_OUTST);
    localparam int CW = $clog2(MAX_OUTST + 1);

    logic [NUM_COL-1:0] arbGrant;
    logic [IW-1:0]      arbIdx;
    logic               grantEn;
    logic               grantFire;
    logic               popFire;
    logic               fifoEmpty;
    logic [IW-1:0]      head;

    ar_req_t       slot_q,       slot_d;
    logic          slotValid_q,  slotValid_d;
    logic [CW-1:0] outst_q,      outst_d;
    logic [PW-1:0] wrPtr_q,      wrPtr_d;
    logic [PW-1:0] rdPtr_q,      rdPtr_d;
    logic          errOrphan_q,  errOrphan_d;
    logic [IW-1:0] fifoMem_q [MAX_OUTST];

    rr_arbiter #(.N(NUM_COL)) uArb (
        .clk_i      (ap_clk),
        .rst_i      (areset),
        .req_i      (col_arvalid),
        .advance_i  (grantFire),
        .grant_o    (arbGrant),
        .grantIdx_o (arbIdx)
    );

    // The occupancy test uses the registered count so a same-cycle last beat never frees a slot early.
    assign grantEn   = (!slotValid_q || hbm_arready) && (outst_q < CW'(MAX_OUTST));
    assign grantFire = grantEn && (|col_arvalid);
    assign fifoEmpty = (outst_q == '0);
    assign head      = fifoMem_q[rdPtr_q];
    assign popFire   = hbm_rvalid && hbm_rready && hbm_rlast && !fifoEmpty;

    assign col_arready = (grantEn && !areset) ? arbGrant : '0;
    assign hbm_arvalid = slotValid_q;
    assign hbm_araddr  = slot_q.addr[ADDR_W-1:0];
    assign hbm_arlen   = slot_q.len;
    assign col_rdata   = areset ? '0 : hbm_rdata;
    assign err_orphan  = errOrphan_q;

    always_comb begin
        col_rvalid = '0;
        col_rlast  = '0;
        hbm_rready = 1'b0;
        if (!areset) begin
            if (fifoEmpty) begin
                hbm_rready = 1'b1;
            end else begin
                col_rvalid[head] = hbm_rvalid;
                col_rlast[head]  = hbm_rlast;
                hbm_rready       = col_rready[head];
            end
        end
    end

    always_comb begin
        slot_d      = slot_q;
        slotValid_d = slotValid_q;
        outst_d     = outst_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        errOrphan_d = errOrphan_q || (hbm_rvalid && fifoEmpty);
        if (slotValid_q && hbm_arready) begin
            slotValid_d = 1'b0;
        end
        if (grantFire) begin
            slotValid_d = 1'b1;
            slot_d.addr = AXI_ADDR_W'(col_araddr[arbIdx*ADDR_W +: ADDR_W]);
            slot_d.len  = col_arlen[arbIdx*AXI_LEN_W +: AXI_LEN_W];
            wrPtr_d     = wrPtr_q + PW'(1);
        end
        if (popFire) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        if (grantFire && !popFire) begin
            outst_d = outst_q + CW'(1);
        end else if (popFire && !grantFire) begin
            outst_d = outst_q - CW'(1);
        end
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            slot_q      <= '0;
            slotValid_q <= 1'b0;
            outst_q     <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            errOrphan_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            slotValid_q <= slotValid_d;
            outst_q     <= outst_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            errOrphan_q <= errOrphan_d;
        end
    end

    // Entries are only read while counted as outstanding, so the storage needs no reset.
    always_ff @(posedge ap_clk) begin
        if (grantFire) begin
            fifoMem_q[wrPtr_q] <= arbIdx;
        end
    end

endmodule

// File: tb/tb_hbm_rd_arbiter.sv
// Directed bench for hbm_rd_arbiter: expected grants, AR issues and R routing are
// queued as stimulus is driven and consumed by a negedge monitor.
module tb_hbm_rd_arbiter;

    localparam int NUM_COL   = 4;
    localparam int ADDR_W    = 64;
    localparam int DATA_W    = 512;
    localparam int MAX_OUTST = 8;

    logic                      ap_clk;
    logic                      areset;
    logic [NUM_COL*ADDR_W-1:0] col_araddr;
    logic [NUM_COL*8-1:0]      col_arlen;
    logic [NUM_COL-1:0]        col_arvalid;
    logic [NUM_COL-1:0]        col_arready;
    logic [DATA_W-1:0]         col_rdata;
    logic [NUM_COL-1:0]        col_rlast;
    logic [NUM_COL-1:0]        col_rvalid;
    logic [NUM_COL-1:0]        col_rready;
    logic [ADDR_W-1:0]         hbm_araddr;
    logic [7:0]                hbm_arlen;
    logic                      hbm_arvalid;
    logic                      hbm_arready;
    logic [DATA_W-1:0]         hbm_rdata;
    logic                      hbm_rlast;
    logic                      hbm_rvalid;
    logic                      hbm_rready;
    logic                      err_orphan;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } arExp_t;

    typedef struct {
        logic [3:0]  vmask;
        logic [3:0]  lmask;
        logic [63:0] data;
    } beatExp_t;

    int       expGrantQ[$];
    arExp_t   expArQ[$];
    beatExp_t expBeatQ[$];

    int compareCount  = 0;
    int mismatchCount = 0;

    hbm_rd_arbiter #(
        .NUM_COL   (NUM_COL),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .ap_clk      (ap_clk),
        .areset      (areset),
        .col_araddr  (col_araddr),
        .col_arlen   (col_arlen),
        .col_arvalid (col_arvalid),
        .col_arready (col_arready),
        .col_rdata   (col_rdata),
        .col_rlast   (col_rlast),
        .col_rvalid  (col_rvalid),
        .col_rready  (col_rready),
        .hbm_araddr  (hbm_araddr),
        .hbm_arlen   (hbm_arlen),
        .hbm_arvalid (hbm_arvalid),
        .hbm_arready (hbm_arready),
        .hbm_rdata   (hbm_rdata),
        .hbm_rlast   (hbm_rlast),
        .hbm_rvalid  (hbm_rvalid),
        .hbm_rready  (hbm_rready),
        .err_orphan  (err_orphan)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic setReq(input int c, input logic [63:0] addr, input logic [7:0] len);
        col_araddr[c*ADDR_W +: ADDR_W] = addr;
        col_arlen[c*8 +: 8]            = len;
    endtask

    task automatic expectGrant(input int c, input logic [63:0] addr, input logic [7:0] len);
        arExp_t a;
        a.addr = addr;
        a.len  = len;
        expGrantQ.push_back(c);
        expArQ.push_back(a);
    endtask

    task automatic applyStimulus(input logic [3:0] vmask, input logic last, input logic [63:0] data);
        beatExp_t b;
        b.vmask = vmask;
        b.lmask = last ? vmask : 4'b0000;
        b.data  = data;
        expBeatQ.push_back(b);
        hbm_rvalid = 1'b1;
        hbm_rlast  = last;
        hbm_rdata  = DATA_W'(data);
    endtask

    task automatic idleR();
        hbm_rvalid = 1'b0;
        hbm_rlast  = 1'b0;
        hbm_rdata  = '0;
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_pending"}, 64'(expGrantQ.size() + expArQ.size() + expBeatQ.size()), 64'd0);
    endtask

    task automatic doReset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        tick();
    endtask

    // Every observed handshake must match the oldest expectation of its kind.
    always @(negedge ap_clk) begin
        if (!areset) begin
            if (col_arready != '0) begin
                if (expGrantQ.size() == 0) begin
                    checkOutput("grant_unexpected", 64'(col_arready), 64'd0);
                end else begin
                    int g;
                    logic [3:0] oh;
                    g  = expGrantQ.pop_front();
                    oh = 4'b0001 << g;
                    checkOutput("grant_col", 64'(col_arready), 64'(oh));
                end
            end
            if (hbm_arvalid && hbm_arready) begin
                if (expArQ.size() == 0) begin
                    checkOutput("ar_unexpected", 64'(hbm_arvalid), 64'd0);
                end else begin
                    arExp_t a;
                    a = expArQ.pop_front();
                    checkOutput("ar_addr", hbm_araddr, a.addr);
                    checkOutput("ar_len", 64'(hbm_arlen), 64'(a.len));
                end
            end
            if (hbm_rvalid && hbm_rready) begin
                if (expBeatQ.size() == 0) begin
                    checkOutput("beat_unexpected", 64'(hbm_rvalid), 64'd0);
                end else begin
                    beatExp_t b;
                    b = expBeatQ.pop_front();
                    checkOutput("r_valid", 64'(col_rvalid), 64'(b.vmask));
                    checkOutput("r_last", 64'(col_rlast), 64'(b.lmask));
                    checkOutput("r_data", col_rdata[63:0], b.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        areset      = 1'b1;
        col_araddr  = '0;
        col_arlen   = '0;
        col_arvalid = 4'b1111;
        col_rready  = 4'b1111;
        hbm_arready = 1'b1;
        hbm_rvalid  = 1'b1;
        hbm_rlast   = 1'b1;
        hbm_rdata   = DATA_W'(64'hDEAD_BEEF);

        #3;
        checkOutput("rst_arready", 64'(col_arready), 64'd0);
        checkOutput("rst_arvalid", 64'(hbm_arvalid), 64'd0);
        checkOutput("rst_rready", 64'(hbm_rready), 64'd0);
        checkOutput("rst_rvalid", 64'(col_rvalid), 64'd0);
        checkOutput("rst_rdata", col_rdata[63:0], 64'd0);
        checkOutput("rst_orphan", 64'(err_orphan), 64'd0);
        col_arvalid = '0;
        idleR();
        tick();
        areset = 1'b0;
        tick();

        // Test 1: single request from column 2.
        $display("[TB] test 1: single request");
        setReq(2, 64'h1000, 8'd3);
        col_arvalid = 4'b0100;
        expectGrant(2, 64'h1000, 8'd3);
        tick();
        col_arvalid = '0;
        #2;
        checkOutput("t1_arvalid_latency", 64'(hbm_arvalid), 64'd1);
        checkOutput("t1_araddr", hbm_araddr, 64'h1000);
        tick();
        for (int b = 0; b < 4; b++) begin
            applyStimulus(4'b0100, (b == 3), 64'hB000 + 64'(b));
            tick();
        end
        idleR();
        col_rready = '0;
        #2;
        checkOutput("t1_fifo_empty_rready", 64'(hbm_rready), 64'd1);
        checkDrained("t1");
        col_rready = 4'b1111;

        // Test 2: fairness with all columns requesting from a reset pointer.
        $display("[TB] test 2: fairness");
        doReset();
        for (int c = 0; c < NUM_COL; c++) setReq(c, 64'h100 * 64'(c + 1), 8'd0);
        col_arvalid = 4'b1111;
        expectGrant(0, 64'h100, 8'd0);
        expectGrant(1, 64'h200, 8'd0);
        expectGrant(2, 64'h300, 8'd0);
        expectGrant(3, 64'h400, 8'd0);
        expectGrant(0, 64'h100, 8'd0);
        for (int i = 0; i < 5; i++) tick();
        col_arvalid = '0;
        tick();
        begin
            int order[5] = '{0, 1, 2, 3, 0};
            for (int i = 0; i < 5; i++) begin
                applyStimulus(4'b0001 << order[i], 1'b1, 64'hC000 + 64'(i));
                tick();
            end
        end
        idleR();
        #2;
        checkDrained("t2");

        // Test 3: AR backpressure holds the slot and blocks further grants.
        $display("[TB] test 3: backpressure");
        hbm_arready = 1'b0;
        setReq(1, 64'h2000, 8'd1);
        col_arvalid = 4'b0010;
        expectGrant(1, 64'h2000, 8'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t3_hold_valid", 64'(hbm_arvalid), 64'd1);
            checkOutput("t3_hold_addr", hbm_araddr, 64'h2000);
            checkOutput("t3_hold_len", 64'(hbm_arlen), 64'd1);
        end
        col_arvalid = '0;
        hbm_arready = 1'b1;
        tick();
        for (int b = 0; b < 2; b++) begin
            applyStimulus(4'b0010, (b == 1), 64'hD000 + 64'(b));
            tick();
        end
        idleR();
        #2;
        checkDrained("t3");

        // Test 4: outstanding limit, released one cycle after a last beat.
        $display("[TB] test 4: outstanding limit");
        col_arvalid = 4'b0001;
        for (int i = 0; i < MAX_OUTST; i++) begin
            setReq(0, 64'h3000 + 64'(i) * 64'h40, 8'd0);
            expectGrant(0, 64'h3000 + 64'(i) * 64'h40, 8'd0);
            tick();
        end
        setReq(0, 64'h3200, 8'd0);
        for (int i = 0; i < 3; i++) begin
            #2;
            checkOutput("t4_blocked", 64'(col_arready), 64'd0);
            tick();
        end
        applyStimulus(4'b0001, 1'b1, 64'hE000);
        #2;
        checkOutput("t4_no_bypass", 64'(col_arready), 64'd0);
        tick();
        idleR();
        expectGrant(0, 64'h3200, 8'd0);
        #2;
        checkOutput("t4_released", 64'(col_arready), 64'd1);
        tick();
        col_arvalid = '0;
        for (int i = 0; i < MAX_OUTST; i++) begin
            applyStimulus(4'b0001, 1'b1, 64'hE100 + 64'(i));
            tick();
        end
        idleR();
        #2;
        checkDrained("t4");

        // Test 5: grant order 3 then 0, with column 3 stalling its first beat.
        $display("[TB] test 5: ordering and stall");
        setReq(3, 64'h4000, 8'd1);
        setReq(0, 64'h5000, 8'd0);
        col_arvalid = 4'b1000;
        expectGrant(3, 64'h4000, 8'd1);
        tick();
        col_arvalid = 4'b0001;
        expectGrant(0, 64'h5000, 8'd0);
        tick();
        col_arvalid = '0;
        tick();
        col_rready = 4'b0111;
        hbm_rvalid = 1'b1;
        hbm_rlast  = 1'b0;
        hbm_rdata  = DATA_W'(64'hF000);
        for (int i = 0; i < 2; i++) begin
            #2;
            checkOutput("t5_stall_rready", 64'(hbm_rready), 64'd0);
            checkOutput("t5_stall_rvalid", 64'(col_rvalid), 64'h8);
            tick();
        end
        col_rready = 4'b1111;
        applyStimulus(4'b1000, 1'b0, 64'hF000);
        tick();
        applyStimulus(4'b1000, 1'b1, 64'hF001);
        tick();
        applyStimulus(4'b0001, 1'b1, 64'hF002);
        tick();
        idleR();
        #2;
        checkDrained("t5");

        // Test 6: orphan beat, then reset in the middle of a burst.
        $display("[TB] test 6: orphan and reset");
        col_rready = '0;
        #2;
        checkOutput("t6_orphan_before", 64'(err_orphan), 64'd0);
        applyStimulus(4'b0000, 1'b1, 64'hAA);
        #2;
        checkOutput("t6_orphan_drain", 64'(hbm_rready), 64'd1);
        checkOutput("t6_orphan_rvalid", 64'(col_rvalid), 64'd0);
        tick();
        idleR();
        #2;
        checkOutput("t6_orphan_set", 64'(err_orphan), 64'd1);
        tick();
        tick();
        checkOutput("t6_orphan_sticky", 64'(err_orphan), 64'd1);

        col_rready = 4'b1111;
        setReq(2, 64'h6000, 8'd3);
        col_arvalid = 4'b0100;
        expectGrant(2, 64'h6000, 8'd3);
        tick();
        col_arvalid = '0;
        tick();
        applyStimulus(4'b0100, 1'b0, 64'h7000);
        tick();
        hbm_rvalid  = 1'b1;
        hbm_rlast   = 1'b0;
        hbm_rdata   = DATA_W'(64'h7001);
        col_arvalid = 4'b0100;
        #2;
        areset = 1'b1;
        #1;
        checkOutput("t6_rst_rvalid", 64'(col_rvalid), 64'd0);
        checkOutput("t6_rst_rlast", 64'(col_rlast), 64'd0);
        checkOutput("t6_rst_rready", 64'(hbm_rready), 64'd0);
        checkOutput("t6_rst_arvalid", 64'(hbm_arvalid), 64'd0);
        checkOutput("t6_rst_arready", 64'(col_arready), 64'd0);
        checkOutput("t6_rst_rdata", col_rdata[63:0], 64'd0);
        checkOutput("t6_rst_orphan", 64'(err_orphan), 64'd0);
        tick();
        idleR();
        col_arvalid = '0;
        col_rready  = '0;
        areset      = 1'b0;
        #2;
        checkOutput("t6_post_rready", 64'(hbm_rready), 64'd1);
        checkOutput("t6_post_orphan", 64'(err_orphan), 64'd0);
        tick();
        checkDrained("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
